fetch_stage: RTL
================

Name: fetch_stage

Overview:
- PC generation plus IF/ID pipeline register for the five-stage MIPS pipeline.
- Drives the fetch address and read enable into instruction memory. Captures the returned word together with PC+4 into the IF/ID register consumed by decode.
- Handles hazard-unit stall, branch/jump redirect with flush, a one-cycle boot state and a halt state.

Parameters:
- RESET_PC, 32'h0000_0000, PC value loaded on reset; bits [1:0] must be 0.
- HALT_INSTR, 32'hFFFF_FFFF, instruction encoding that stops fetch once latched.

Ports:
- i_clk  input  1  clock; all state updates on rising edge.
- i_reset  input  1  synchronous, active-high reset.
- i_stall  input  1  hazard unit: hold PC and IF/ID contents.
- i_flush  input  1  squash IF/ID (load bubble).
- i_branch_taken  input  1  branch resolved taken; redirect PC.
- i_branch_target  input  32  branch target address.
- i_jump  input  1  jump; redirect PC.
- i_jump_target  input  32  jump target address.
- i_instruction  input  32  combinational instruction word returned by instruction memory for o_pc.
- o_pc  output  32  current fetch address (registered).
- o_read  output  1  instruction memory read enable.
- o_ifid_instr  output  32  IF/ID instruction.
- o_ifid_pc4  output  32  IF/ID PC+4.
- o_ifid_valid  output  1  IF/ID holds a real instruction.
- o_halted  output  1  high while in HALT state.

Behaviour:
- Synchronous, active-high reset, sampled at the rising edge of i_clk. It sets:
  - state=BOOT, o_pc=RESET_PC;
  - o_ifid_instr=0, o_ifid_pc4=0, o_ifid_valid=0;
  - o_halted=0.
- o_read = (state==RUN); purely combinational from the state.
- redirect = i_jump | i_branch_taken. Target = i_jump_target if i_jump, else i_branch_target (jump wins when both are high). Target bits [1:0] forced to 0.
- Per-edge priority: reset > redirect > stall > normal.
- State BOOT:
  - lasts exactly one cycle; PC holds; IF/ID loads a bubble (valid=0, instr=0).
  - Next state is RUN, unless redirect is high: then PC=target, still go to RUN.
- State RUN:
  - redirect: PC<=target; IF/ID<=bubble regardless of i_stall/i_flush.
  - else i_stall=1: PC and IF/ID hold. If i_flush is also high, IF/ID<=bubble while PC holds.
  - else i_flush=1: PC<=PC+4; IF/ID<=bubble.
  - else normal: PC<=PC+4; o_ifid_instr<=i_instruction; o_ifid_pc4<=PC+4; o_ifid_valid<=1.
  - Enter HALT: normal case and i_instruction==HALT_INSTR. The halt word is still latched into IF/ID with valid=1; PC does not advance.
- State HALT:
  - o_halted=1; o_read=0; PC holds; IF/ID loads a bubble every cycle.
  - Redirect exits to RUN with PC<=target, o_halted<=0. This covers a squashed speculative halt.
  - Stall and flush are otherwise ignored.
- Arithmetic: PC+4 is modulo 2^32, so 32'hFFFF_FFFC wraps to 32'h0000_0000 with no flag.
- Latency: fetch at o_pc in cycle N appears on o_ifid_* in cycle N+1.
- Bubble encoding: instr=32'h0000_0000 (MIPS nop), pc4=0, valid=0.
- Reset mid-stall, mid-redirect or in HALT: reset wins and returns to BOOT on the next edge.

Optional Feature:
- Macro FETCH_PERF_EN.
- Defined: adds ports o_fetch_count [31:0] and o_bubble_count [31:0], both reset to 0.
  - o_fetch_count increments on every edge taking the RUN normal path.
  - o_bubble_count increments on every edge loading a bubble into IF/ID, all sources included.
  - Both counters wrap modulo 2^32.
- Undefined: ports and counters absent; all other behaviour identical.

Test Plan:
- Reset/boot: i_reset high 2 cycles then low → o_pc=0, o_read=0, valid=0 for one cycle. Then o_read=1, and fetches PC 0, 4, 8 with o_ifid_pc4=4, 8, 12, valid=1.
- Stall: i_stall high for 3 cycles at PC=8 → o_pc stays 8, o_ifid_instr/pc4 unchanged. After release, PC=12 next cycle.
- Redirect priority:
  - i_jump=1 (target 32'h40) with i_branch_taken=1 (target 32'h80) and i_stall=1 → o_pc=32'h40, valid=0 next cycle.
  - Branch target 32'h83 → o_pc=32'h80.
- Flush without redirect: i_flush=1 at PC=16 → valid=0, instr=0, o_pc=20.
- Halt: memory word at PC 12 = 32'hFFFF_FFFF → IF/ID holds halt word with valid=1, then o_halted=1, o_read=0, o_pc=12 and IF/ID valid=0 on later edges. A later i_branch_taken to 32'h20 → RUN, o_pc=32'h20.
- Wrap and perf counters: RESET_PC=32'hFFFF_FFF8, run 3 normal cycles → o_pc goes FFFF_FFFC, then 0, then 4. With FETCH_PERF_EN defined, after boot plus 3 normal cycles o_fetch_count=3 and o_bubble_count=1.

Source files
------------

// File: rtl/fetch_stage.sv
// fetch_stage: PC generation and IF/ID pipeline register for a five-stage
// MIPS pipeline. A one-cycle BOOT state follows reset, RUN fetches, and
// HALT parks fetch once the halt encoding is latched.
// Optional macro FETCH_PERF_EN adds fetch and bubble counters.
module fetch_stage #(
  parameter logic [31:0] RESET_PC   = 32'h0000_0000,
  parameter logic [31:0] HALT_INSTR = 32'hFFFF_FFFF
) (
  input  logic        i_clk,
  input  logic        i_reset,
  input  logic        i_stall,
  input  logic        i_flush,
  input  logic        i_branch_taken,
  input  logic [31:0] i_branch_target,
  input  logic        i_jump,
  input  logic [31:0] i_jump_target,
  input  logic [31:0] i_instruction,
  output logic [31:0] o_pc,
  output logic        o_read,
  output logic [31:0] o_ifid_instr,
  output logic [31:0] o_ifid_pc4,
  output logic        o_ifid_valid,
  output logic        o_halted
`ifdef FETCH_PERF_EN
  ,
  output logic [31:0] o_fetch_count,
  output logic [31:0] o_bubble_count
`endif
);

  typedef enum logic [1:0] {
    ST_BOOT = 2'd0,
    ST_RUN  = 2'd1,
    ST_HALT = 2'd2
  } state_t;

  state_t      state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic [31:0] ifid_instr_q, ifid_instr_d;
  logic [31:0] ifid_pc4_q, ifid_pc4_d;
  logic        ifid_valid_q, ifid_valid_d;

  logic        redirect;
  logic [31:0] target_sel;
  logic [31:0] target;
  logic [31:0] pc_plus4;
  logic        load_bubble;
  logic        take_normal;

  // Redirect select (jump wins over branch) and word-aligned target.
  always_comb begin
    redirect   = i_jump | i_branch_taken;
    target_sel = i_jump ? i_jump_target : i_branch_target;
    target     = target_sel & 32'hFFFF_FFFC;
    pc_plus4   = pc_q + 32'd4;
  end

  // Next-state logic: redirect beats stall, stall beats flush/normal.
  always_comb begin
    state_d      = state_q;
    pc_d         = pc_q;
    ifid_instr_d = ifid_instr_q;
    ifid_pc4_d   = ifid_pc4_q;
    ifid_valid_d = ifid_valid_q;
    load_bubble  = 1'b0;
    take_normal  = 1'b0;
    case (state_q)
      ST_BOOT: begin
        state_d     = ST_RUN;
        load_bubble = 1'b1;
        if (redirect) pc_d = target;
      end
      ST_RUN: begin
        if (redirect) begin
          pc_d        = target;
          load_bubble = 1'b1;
        end else if (i_stall) begin
          // PC holds; a simultaneous flush still squashes IF/ID.
          load_bubble = i_flush;
        end else if (i_flush) begin
          pc_d        = pc_plus4;
          load_bubble = 1'b1;
        end else begin
          take_normal  = 1'b1;
          ifid_instr_d = i_instruction;
          ifid_pc4_d   = pc_plus4;
          ifid_valid_d = 1'b1;
          // The halt word is delivered to decode but PC stops on it.
          if (i_instruction == HALT_INSTR) state_d = ST_HALT;
          else                             pc_d    = pc_plus4;
        end
      end
      ST_HALT: begin
        load_bubble = 1'b1;
        if (redirect) begin
          pc_d    = target;
          state_d = ST_RUN;
        end
      end
      default: begin
        state_d     = ST_BOOT;
        load_bubble = 1'b1;
      end
    endcase
    if (load_bubble) begin
      ifid_instr_d = 32'h0000_0000;
      ifid_pc4_d   = 32'h0000_0000;
      ifid_valid_d = 1'b0;
    end
  end

  // State, PC and IF/ID registers with synchronous reset.
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      state_q      <= ST_BOOT;
      pc_q         <= RESET_PC;
      ifid_instr_q <= 32'h0000_0000;
      ifid_pc4_q   <= 32'h0000_0000;
      ifid_valid_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      pc_q         <= pc_d;
      ifid_instr_q <= ifid_instr_d;
      ifid_pc4_q   <= ifid_pc4_d;
      ifid_valid_q <= ifid_valid_d;
    end
  end

`ifdef FETCH_PERF_EN
  logic [31:0] fetch_count_q, fetch_count_d;
  logic [31:0] bubble_count_q, bubble_count_d;

  // Counter increments; both wrap naturally at 2^32.
  always_comb begin
    fetch_count_d  = fetch_count_q + {31'd0, take_normal};
    bubble_count_d = bubble_count_q + {31'd0, load_bubble};
  end

  // Performance counter registers.
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      fetch_count_q  <= 32'd0;
      bubble_count_q <= 32'd0;
    end else begin
      fetch_count_q  <= fetch_count_d;
      bubble_count_q <= bubble_count_d;
    end
  end

  assign o_fetch_count  = fetch_count_q;
  assign o_bubble_count = bubble_count_q;
`endif

  assign o_pc         = pc_q;
  assign o_read       = (state_q == ST_RUN);
  assign o_ifid_instr = ifid_instr_q;
  assign o_ifid_pc4   = ifid_pc4_q;
  assign o_ifid_valid = ifid_valid_q;
  assign o_halted     = (state_q == ST_HALT);

endmodule
